// File: rtl/cpu_clken_gen.sv
// cpu_clken_gen: clock-enable generator for the 65C02 bus.
// Provides a runtime-selectable CPU rate, single-step, wait-state stretching,
// a free-running peripheral enable and the phi2 trace phase.
// Optional macro CLKEN_CYCLE_COUNT_EN builds the bus-cycle counter behind
// o_cycle_count; without it the port reads 0.
module cpu_clken_gen #(
    parameter int unsigned DIV          = 16,
    parameter int unsigned PERIPH_RATIO = 4,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [1:0]       i_div_sel,
    input  logic             i_step,
    input  logic             i_wait_req,
    output logic             o_cpu_clken,
    output logic             o_cpu_clken1,
    output logic             o_periph_clken,
    output logic             o_phi2,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int unsigned CntW  = $clog2(4 * DIV);
    localparam int unsigned PDiv  = DIV / PERIPH_RATIO;
    localparam int unsigned PCntW = (PDiv > 1) ? $clog2(PDiv) : 1;
    localparam int unsigned WaitW = 4;

    typedef enum logic [1:0] {
        ModeDiv1 = 2'b00,
        ModeDiv2 = 2'b01,
        ModeDiv4 = 2'b10,
        ModeStep = 2'b11
    } mode_e;

    mode_e             r_mode;
    logic [CntW-1:0]   r_cnt;
    logic [WaitW-1:0]  r_wait_left;
    logic              r_step_q;
    logic              r_step_q2;
    logic              r_step_armed;
    logic              r_cpu_clken;
    logic              r_cpu_clken1;
    logic              r_phi2;
    logic [PCntW-1:0]  r_pcnt;
    logic              r_periph_clken;

    logic [CntW-1:0]   w_last;
    logic [CntW-1:0]   w_half;
    logic              w_end;
    logic              w_waiting;
    logic              w_step_rise;
    logic              w_fire;
    logic              w_wrap;

    // Decode the latched mode into the last and half-period counter values.
    always_comb begin
        w_last = CntW'(DIV - 1);
        w_half = CntW'(DIV / 2 - 1);
        case (r_mode)
            ModeDiv2: begin
                w_last = CntW'(2 * DIV - 1);
                w_half = CntW'(DIV - 1);
            end
            ModeDiv4: begin
                w_last = CntW'(4 * DIV - 1);
                w_half = CntW'(2 * DIV - 1);
            end
            default: ;
        endcase
    end

    assign w_end       = (r_cnt == w_last);
    assign w_waiting   = (r_wait_left != '0);
    assign w_step_rise = r_step_q & ~r_step_q2;
    // A pulse needs no pending wait, and in single-step mode an armed step.
    assign w_fire      = w_end & ~w_waiting & ((r_mode != ModeStep) | r_step_armed);
    // A wait period also restarts the counter; only an unarmed step hold does not.
    assign w_wrap      = w_end & (w_waiting | w_fire);

    // Period counter, mode latch, wait-state and single-step bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_mode       <= ModeDiv1;
            r_wait_left  <= '0;
            r_step_q     <= 1'b0;
            r_step_q2    <= 1'b0;
            r_step_armed <= 1'b0;
        end else begin
            r_step_q  <= i_step;
            r_step_q2 <= r_step_q;

            if (w_wrap) begin
                r_cnt  <= '0;
                r_mode <= mode_e'(i_div_sel);
            end else if (!w_end) begin
                r_cnt <= r_cnt + CntW'(1);
            end

            if (r_cpu_clken1 && i_wait_req) begin
                r_wait_left <= WaitW'(WAIT_CYCLES);
            end else if (w_end && w_waiting) begin
                r_wait_left <= r_wait_left - WaitW'(1);
            end

            // One-deep: an edge arriving while already armed is dropped.
            if (w_fire && r_step_armed) begin
                r_step_armed <= 1'b0;
            end else if (w_step_rise) begin
                r_step_armed <= 1'b1;
            end
        end
    end

    // Registered bus strobes and the phi2 trace phase.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cpu_clken  <= 1'b0;
            r_cpu_clken1 <= 1'b0;
            r_phi2       <= 1'b0;
        end else begin
            r_cpu_clken  <= w_fire;
            r_cpu_clken1 <= r_cpu_clken;
            if (w_fire) begin
                r_phi2 <= 1'b1;
            end else if (r_cnt == w_half) begin
                r_phi2 <= 1'b0;
            end
        end
    end

    // Free-running peripheral enable, phase-locked to reset release only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pcnt         <= '0;
            r_periph_clken <= 1'b0;
        end else begin
            r_periph_clken <= (r_pcnt == PCntW'(PDiv - 1));
            if (r_pcnt == PCntW'(PDiv - 1)) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PCntW'(1);
            end
        end
    end

`ifdef CLKEN_CYCLE_COUNT_EN
    logic [CNT_W-1:0] r_cycle_count;

    // Count bus-cycle pulses; updates on the same edge that raises cpu_clken.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_count <= '0;
        end else if (w_fire) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = '0;
`endif

    assign o_cpu_clken    = r_cpu_clken;
    assign o_cpu_clken1   = r_cpu_clken1;
    assign o_periph_clken = r_periph_clken;
    assign o_phi2         = r_phi2;

endmodule

// File: tb/tb_cpu_clken_gen.sv
// tb_cpu_clken_gen: directed and randomized bench for cpu_clken_gen with a
// cycle-level behavioural reference model of the bus-enable rules.
module tb_cpu_clken_gen;

    localparam int unsigned DIV = 16;
    localparam int unsigned PR  = 4;
    localparam int unsigned WC  = 2;
    localparam int unsigned CW  = 4;
`ifdef CLKEN_CYCLE_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    div_sel = 2'b00;
    logic          step = 1'b0;
    logic          wait_req = 1'b0;
    logic          cpu_clken;
    logic          cpu_clken1;
    logic          periph_clken;
    logic          phi2;
    logic [CW-1:0] cycle_count;

    always #5 clk = ~clk;

    cpu_clken_gen #(
        .DIV          (DIV),
        .PERIPH_RATIO (PR),
        .WAIT_CYCLES  (WC),
        .CNT_W        (CW)
    ) u_dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_div_sel      (div_sel),
        .i_step         (step),
        .i_wait_req     (wait_req),
        .o_cpu_clken    (cpu_clken),
        .o_cpu_clken1   (cpu_clken1),
        .o_periph_clken (periph_clken),
        .o_phi2         (phi2),
        .o_cycle_count  (cycle_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_edge = 0;
    int last_pulse = -1;
    int n_periph = 0;
    int pulses[$];

    // Reference model state: position inside the current bus period and friends.
    int m_pos = 0;
    int m_mode = 0;
    int m_wait = 0;
    bit m_armed = 0;
    bit m_stp1 = 0;
    bit m_stp2 = 0;
    bit m_clken = 0;
    bit m_clken1 = 0;
    bit m_phi2 = 0;
    bit m_periph = 0;
    int m_since_rst = 0;
    int m_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT just sampled.
    task automatic model_edge();
        int len;
        int n_pos;
        int n_mode;
        int n_wait;
        bit fire;
        bit rise;
        bit n_armed;
        bit n_phi2;
        if (rst) begin
            m_pos = 0; m_mode = 0; m_wait = 0; m_armed = 0;
            m_stp1 = 0; m_stp2 = 0; m_clken = 0; m_clken1 = 0;
            m_phi2 = 0; m_periph = 0; m_since_rst = 0; m_count = 0;
        end else begin
            len    = (m_mode == 3) ? DIV : (DIV << m_mode);
            n_pos  = m_pos + 1;
            n_mode = m_mode;
            n_wait = m_wait;
            fire   = 0;
            if (m_pos == len - 1) begin
                if (m_wait != 0) begin
                    n_wait = m_wait - 1;
                    n_pos  = 0;
                    n_mode = int'(div_sel);
                end else if (m_mode == 3 && !m_armed) begin
                    n_pos = m_pos;
                end else begin
                    fire   = 1;
                    n_pos  = 0;
                    n_mode = int'(div_sel);
                end
            end
            if (m_clken1 && wait_req) n_wait = WC;
            rise    = m_stp1 && !m_stp2;
            n_armed = m_armed;
            if (fire && m_armed) n_armed = 0;
            else if (rise) n_armed = 1;
            if (fire) n_phi2 = 1;
            else if (m_pos == len / 2 - 1) n_phi2 = 0;
            else n_phi2 = m_phi2;
            m_since_rst++;
            m_periph = (m_since_rst % (DIV / PR)) == 0;
            m_clken1 = m_clken;
            m_clken  = fire;
            if (fire && CountEn) m_count = (m_count + 1) % (1 << CW);
            m_stp2  = m_stp1;
            m_stp1  = step;
            m_pos   = n_pos;
            m_mode  = n_mode;
            m_wait  = n_wait;
            m_armed = n_armed;
            m_phi2  = n_phi2;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        if (rst) n_edge = 0;
        else n_edge++;
        #1;
        check_eq("cpu_clken", cpu_clken, m_clken);
        check_eq("cpu_clken1", cpu_clken1, m_clken1);
        check_eq("periph_clken", periph_clken, m_periph);
        check_eq("phi2", phi2, m_phi2);
        check_eq("cycle_count", cycle_count, m_count);
        if (cpu_clken) begin
            pulses.push_back(n_edge);
            last_pulse = n_edge;
        end
        if (periph_clken) n_periph++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pulse(input int budget);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!cpu_clken && k < budget);
        check_eq("pulse_wait", cpu_clken, 1);
    endtask

    task automatic wait_clken1(input int budget);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!cpu_clken1 && k < budget);
        check_eq("clken1_wait", cpu_clken1, 1);
    endtask

    initial begin
        int k;
        int p;
        int exp_step[3];

        // Reset and first periods at the base rate.
        rst = 1'b1;
        run(3);
        check_eq("rst_clken", cpu_clken, 0);
        check_eq("rst_phi2", phi2, 0);
        rst = 1'b0;
        pulses.delete();
        run(48);
        check_eq("base_count", pulses.size(), 3);
        check_eq("first_pulse", (pulses.size() > 0) ? pulses[0] : -1, 16);
        check_eq("third_pulse", last_pulse, 48);

        // Mid-period switch to 4*DIV: current period still ends at 16 clks.
        pulses.delete();
        run(5);
        div_sel = 2'b10;
        run(145);
        check_eq("div4_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check_eq("div4_p0", pulses[0], 64);
            check_eq("div4_p1", pulses[1], 128);
            check_eq("div4_p2", pulses[2], 192);
        end

        // Wait state accepted during cpu_clken1 stretches the next cycle.
        div_sel = 2'b00;
        run(80);
        wait_clken1(40);
        k = last_pulse;
        wait_req = 1'b1;
        cycle();
        wait_req = 1'b0;
        wait_pulse(100);
        check_eq("wait_gap", last_pulse - k, (1 + WC) * DIV);
        k = last_pulse;
        run(3);
        wait_req = 1'b1;
        run(8);
        wait_req = 1'b0;
        wait_pulse(40);
        check_eq("stray_wait_gap", last_pulse - k, DIV);

        // Single-step mode: idle, then three spaced steps.
        div_sel = 2'b11;
        run(40);
        pulses.delete();
        n_periph = 0;
        run(1000);
        check_eq("step_idle_pulses", pulses.size(), 0);
        check_eq("step_idle_periph", n_periph, 1000 / (DIV / PR));
        pulses.delete();
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            cycle();
            exp_step[i] = n_edge + 2;
            run(4);
            step = 1'b0;
            run(45);
        end
        check_eq("step_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            for (int i = 0; i < 3; i++) check_eq("step_latency", pulses[i], exp_step[i]);
        end

        // Two edges before the pulse yield only one pulse.
        step = 1'b1;
        cycle();
        step = 1'b0;
        wait_pulse(20);
        p = last_pulse;
        pulses.delete();
        step = 1'b1;
        cycle();
        step = 1'b0;
        run(2);
        step = 1'b1;
        cycle();
        step = 1'b0;
        run(60);
        check_eq("double_step_count", pulses.size(), 1);
        check_eq("double_step_time", last_pulse, p + DIV);

        // Reset during a wait stretch with a step armed.
        step = 1'b1;
        cycle();
        step = 1'b0;
        wait_clken1(20);
        wait_req = 1'b1;
        step = 1'b1;
        cycle();
        wait_req = 1'b0;
        run(2);
        step = 1'b0;
        run(20);
        rst = 1'b1;
        div_sel = 2'b00;
        cycle();
        check_eq("mid_rst_clken", cpu_clken, 0);
        check_eq("mid_rst_clken1", cpu_clken1, 0);
        check_eq("mid_rst_periph", periph_clken, 0);
        check_eq("mid_rst_phi2", phi2, 0);
        check_eq("mid_rst_count", cycle_count, 0);
        rst = 1'b0;
        pulses.delete();
        run(20);
        check_eq("post_rst_count", pulses.size(), 1);
        check_eq("post_rst_first", last_pulse, 16);

        // Cycle counter wrap at 2^CW.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        pulses.delete();
        k = 0;
        while (pulses.size() < 15 && k < 400) begin
            cycle();
            k++;
        end
        check_eq("count_15", cycle_count, CountEn ? 15 : 0);
        wait_pulse(40);
        check_eq("count_wrap", cycle_count, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) div_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) step = ~step;
            wait_req = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 599) == 0);
            cycle();
        end
        rst = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
